// File: rtl/dut_if.sv
// myBus: bundle carrying the clock, reset, controls and counter outputs of dut.
//   clk       : single clock, rising edge active
//   rst       : synchronous active-high reset
//   enable    : advance the counter when high
//   mode      : 0 up, 1 down, 2 rotate-left, 3 load
//   load_val  : value captured in mode 3
//   data      : registered counter value
//   wrap      : one-cycle boundary pulse
//   active    : enable delayed by one cycle
// Modport DUT is the view used by the counter itself.
interface myBus #(
   parameter int WIDTH = 8
);
   logic             clk;
   logic             rst;
   logic             enable;
   logic [1:0]       mode;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] data;
   logic             wrap;
   logic             active;

   modport DUT (
      input  clk,
      input  rst,
      input  enable,
      input  mode,
      input  load_val,
      output data,
      output wrap,
      output active
   );
endinterface

// File: rtl/dut.sv
// dut: WIDTH-bit up/down/rotate/load counter with a boundary pulse.
// Ports (all through bus, modport myBus.DUT):
//   clk, rst (sync, active-high), enable, mode[1:0], load_val[WIDTH-1:0]
//   data[WIDTH-1:0], wrap, active  -- all registered, latency 1 cycle.
// Optional feature: define DUT_SATURATE_EN to make up/down counting stick
// at all-ones / zero instead of wrapping. wrap then pulses once when a step
// is first blocked at the limit and stays low while the counter is pinned.
module dut #(
   parameter int WIDTH = 8
) (
   myBus.DUT bus
);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] data_reg, data_next;
   logic             wrap_reg, wrap_next;
   logic             active_reg, active_next;

`ifdef DUT_SATURATE_EN
   // Set once a step has been blocked at a limit; suppresses repeat pulses.
   logic pinned_reg, pinned_next;
`endif

   always_comb begin
      data_next   = data_reg;
      wrap_next   = 1'b0;
      active_next = bus.enable;
`ifdef DUT_SATURATE_EN
      pinned_next = pinned_reg;
`endif
      if (bus.enable) begin
`ifdef DUT_SATURATE_EN
         // Any enabled operation that is not a blocked step releases the pin.
         pinned_next = 1'b0;
`endif
         case (bus.mode)
            2'd0: begin
               if (data_reg == ALL_ONES) begin
`ifdef DUT_SATURATE_EN
                  wrap_next   = ~pinned_reg;
                  pinned_next = 1'b1;
`else
                  data_next = '0;
                  wrap_next = 1'b1;
`endif
               end else begin
                  data_next = data_reg + 1'b1;
               end
            end
            2'd1: begin
               if (data_reg == '0) begin
`ifdef DUT_SATURATE_EN
                  wrap_next   = ~pinned_reg;
                  pinned_next = 1'b1;
`else
                  data_next = ALL_ONES;
                  wrap_next = 1'b1;
`endif
               end else begin
                  data_next = data_reg - 1'b1;
               end
            end
            2'd2: data_next = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
            default: data_next = bus.load_val;
         endcase
      end
   end

   always_ff @(posedge bus.clk) begin
      if (bus.rst) begin
         data_reg   <= '0;
         wrap_reg   <= 1'b0;
         active_reg <= 1'b0;
      end else begin
         data_reg   <= data_next;
         wrap_reg   <= wrap_next;
         active_reg <= active_next;
      end
   end

`ifdef DUT_SATURATE_EN
   always_ff @(posedge bus.clk) begin
      if (bus.rst) begin
         pinned_reg <= 1'b0;
      end else begin
         pinned_reg <= pinned_next;
      end
   end
`endif

   assign bus.data   = data_reg;
   assign bus.wrap   = wrap_reg;
   assign bus.active = active_reg;
endmodule

// File: tb/tb_dut.sv
// tb_dut: directed vector table for the documented scenarios, then random
// stimulus checked against an arithmetic reference model.
module tb_dut;
`ifdef DUT_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   myBus #(.WIDTH(8)) bus ();
   dut #(.WIDTH(8)) u_dut (.bus(bus));

   initial bus.clk = 1'b0;
   always #5 bus.clk = ~bus.clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [7:0] lv;
      logic [7:0] ed;
      logic       ew;
      logic       ea;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   // Reference model state (plain integers).
   int  m_data;
   bit  m_pinned;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic en, input logic [1:0] m,
                        input logic [7:0] lv, input logic [7:0] ed,
                        input logic ew, input logic ea, input string tag);
      bus.rst      = r;
      bus.enable   = en;
      bus.mode     = m;
      bus.load_val = lv;
      @(posedge bus.clk);
      #1;
      $display("TXN %s rst=%0b en=%0b mode=%0d lv=%02h -> data=%02h wrap=%0b active=%0b",
               tag, r, en, m, lv, bus.data, bus.wrap, bus.active);
      check({tag, ".data"}, int'(bus.data), int'(ed));
      check({tag, ".wrap"}, int'(bus.wrap), int'(ew));
      check({tag, ".active"}, int'(bus.active), int'(ea));
   endtask

   // Model one edge from the rules: returns expected data/wrap/active.
   task automatic model_step(input bit r, input bit en, input int m, input int lv,
                             output logic [7:0] ed, output logic ew, output logic ea);
      bit blocked;
      ew = 1'b0;
      ea = en;
      if (r) begin
         m_data = 0; m_pinned = 0; ea = 1'b0;
      end else if (en) begin
         blocked = SAT && ((m == 0 && m_data == 255) || (m == 1 && m_data == 0));
         if (blocked) begin
            ew = !m_pinned;
            m_pinned = 1;
         end else begin
            m_pinned = 0;
            case (m)
               0: begin ew = (m_data == 255); m_data = (m_data + 1) % 256; end
               1: begin ew = (m_data == 0);   m_data = (m_data + 255) % 256; end
               2: m_data = ((m_data * 2) % 256) + (m_data / 128);
               default: m_data = lv;
            endcase
         end
      end
      ed = 8'(m_data);
   endtask

   initial begin
      logic [7:0] ed;
      logic ew, ea, r, en;
      logic [1:0] m;
      logic [7:0] lv;

      bus.rst = 1'b1; bus.enable = 1'b0; bus.mode = 2'd0; bus.load_val = 8'h00;

      // Reset then idle.
      vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0});
      for (int i = 0; i < 3; i++) vecs.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 0});
      // Up count with a gap in enable: 2 + 5 steps -> 7.
      vecs.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 1});
      vecs.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 1});
      vecs.push_back('{0, 0, 0, 8'h00, 8'h02, 0, 0});
      for (int i = 3; i <= 7; i++) vecs.push_back('{0, 1, 0, 8'h00, 8'(i), 0, 1});
      // Load FF then step up: wrap (or saturate), then one more step.
      vecs.push_back('{0, 1, 3, 8'hFF, 8'hFF, 0, 1});
      vecs.push_back('{0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h00, 1, 1});
      vecs.push_back('{0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h01, 0, 1});
      // Load 81 then rotate left.
      vecs.push_back('{0, 1, 3, 8'h81, 8'h81, 0, 1});
      vecs.push_back('{0, 1, 2, 8'h00, 8'h03, 0, 1});
      // Down from 0: wrap (or pin), then a second down step.
      vecs.push_back('{0, 1, 3, 8'h00, 8'h00, 0, 1});
      vecs.push_back('{0, 1, 1, 8'h00, SAT ? 8'h00 : 8'hFF, 1, 1});
      vecs.push_back('{0, 1, 1, 8'h00, SAT ? 8'h00 : 8'hFE, 0, 1});
      // Count to 5, reset mid-count with enable high, resume from 0.
      vecs.push_back('{1, 0, 0, 8'h00, 8'h00, 0, 0});
      for (int i = 1; i <= 5; i++) vecs.push_back('{0, 1, 0, 8'h00, 8'(i), 0, 1});
      vecs.push_back('{1, 1, 0, 8'h00, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 1});
      // Enable toggling every cycle across mode changes.
      vecs.push_back('{0, 0, 1, 8'h00, 8'h01, 0, 0});
      vecs.push_back('{0, 1, 1, 8'h00, 8'h00, 0, 1});
      vecs.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 1});

      foreach (vecs[i])
         apply(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].lv,
               vecs[i].ed, vecs[i].ew, vecs[i].ea, $sformatf("vec%0d", i));

      // Random phase: start from a known reset, then free-running stimulus.
      m_data = 0; m_pinned = 0;
      model_step(1, 0, 0, 0, ed, ew, ea);
      apply(1, 0, 0, 8'h00, ed, ew, ea, "rnd_rst");
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 29) == 0);
         en = ($urandom_range(0, 3) != 0);
         m  = 2'($urandom_range(0, 3));
         // Bias loads toward the limits to exercise boundary steps.
         case ($urandom_range(0, 3))
            0: lv = 8'hFF;
            1: lv = 8'h00;
            default: lv = 8'($urandom);
         endcase
         model_step(r, en, int'(m), int'(lv), ed, ew, ea);
         apply(r, en, m, lv, ed, ew, ea, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dut.md
DUT -- requirements
Module: dut

Interface
REQ-001 Parameter: WIDTH, default 8, width of the data counter carried on myBus.
REQ-002 Module port: bus, myBus.DUT modport, sole port of dut; all signals below are reached through it.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  advances the counter when high; state holds when low.
REQ-006 mode  input  2  operation select: 0 up, 1 down, 2 rotate-left, 3 load.
REQ-007 load_val  input  WIDTH  value captured in mode 3.
REQ-008 data  output  WIDTH  registered counter value.
REQ-009 wrap  output  1  one-cycle pulse when an up/down step crosses a boundary.
REQ-010 active  output  1  registered copy of enable, delayed one cycle.

Function
REQ-011 All outputs SHALL be registered; the effect of an input sampled at edge N SHALL appear after edge N, with latency 1 cycle.
REQ-012 enable=0: data SHALL hold, wrap SHALL be 0, active SHALL be 0 after the next edge.
REQ-013 enable=1, mode=0: data SHALL become data+1 modulo 2^WIDTH.
REQ-014 enable=1, mode=1: data SHALL become data-1 modulo 2^WIDTH.
REQ-015 enable=1, mode=2: data SHALL rotate left by one bit, MSB into LSB; wrap SHALL be 0.
REQ-016 enable=1, mode=3: data SHALL become load_val; wrap SHALL be 0.
REQ-017 wrap SHALL be 1 for exactly one cycle when mode 0 steps all-ones to 0, or mode 1 steps 0 to all-ones; otherwise wrap SHALL be 0.
REQ-018 A mode change SHALL take effect on the same edge at which it is sampled; there is no pipeline flush or extra penalty cycle.
REQ-019 enable toggling every cycle SHALL advance data exactly once per cycle in which enable is sampled high.
REQ-020 Arithmetic SHALL be unsigned WIDTH-bit; no carry out beyond wrap.

Reset
REQ-021 rst=1 at a rising edge SHALL set data=0, wrap=0 and active=0, overriding enable and mode.
REQ-022 Reset asserted mid-count SHALL take effect at the next edge with no partial update; counting SHALL resume from 0 on the first edge after rst deasserts with enable=1.
REQ-023 Before the first reset, output values are undefined; the bench SHALL apply reset before checking.

Configuration
REQ-024 Macro DUT_SATURATE_EN.
REQ-025 When defined: mode 0 SHALL hold at all-ones and mode 1 SHALL hold at 0 instead of wrapping; wrap SHALL pulse once on the cycle an enabled step is blocked at the limit, then stay 0 while the counter remains pinned.
REQ-026 When undefined: modulo wrap behaviour per REQ-013/014/017; no saturation logic is present.

Verification
REQ-027 Reset, then enable=0 for 3 cycles -> data=0, wrap=0, active=0.
REQ-028 mode=0, enable high for 2 cycles, low for 1 cycle, high for 5 cycles -> data=7, active follows enable with 1-cycle delay.
REQ-029 mode=3 load_val=8'hFF, then mode=0 for 1 cycle -> data=0x00, wrap=1 for one cycle (DUT_SATURATE_EN defined: data=0xFF, wrap=1 once).
REQ-030 mode=3 load_val=8'h81, then mode=2 for 1 cycle -> data=0x03, wrap=0.
REQ-031 data=0, mode=1 for 1 cycle -> data=0xFF, wrap=1 (DUT_SATURATE_EN defined: data=0x00).
REQ-032 Count to 5, assert rst for 1 cycle with enable=1 -> data=0; next enabled mode-0 cycle -> data=1.
